// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// the FSM state type and the default operand width.
package divider_pkg;

    localparam int DEFAULT_N = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration, purely combinational: shift {A,Q} left,
// trial-subtract the divisor and either keep the difference (quotient bit 1)
// or restore the shifted partial remainder (quotient bit 0).
module divider_step
    import divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N:0]   a,
    input  logic [N-1:0] q,
    input  logic [N-1:0] m,
    output logic [N:0]   a_next,
    output logic [N-1:0] q_next
);

    logic [2*N:0] aq_shift;
    logic [N:0]   a_sh;
    logic [N-1:0] q_sh;
    logic [N:0]   t;

    // Shift, trial subtract and select between difference and restored value.
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        aq_shift = {a, q} << 1;
        a_sh     = aq_shift[2*N:N];
        q_sh     = aq_shift[N-1:0];
        t        = a_sh - {1'b0, m};
        q_next   = q_sh | {{(N-1){1'b0}}, ~t[N]};
        if (t[N] == 1'b0) begin
            a_next = t;
        end else begin
            a_next = a_sh;
        end
    end

endmodule

// File: rtl/divider_restoring.sv
// Sequential unsigned restoring divider, one quotient bit per clock under a
// start/busy/done handshake. Results hold until the next accepted start.
// Optional feature: define DIVIDER_DBZ_EN to add the div_by_zero output and a
// one-cycle shortcut for a zero divisor.
module divider_restoring
    import divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
`ifdef DIVIDER_DBZ_EN
    ,
    output logic         div_by_zero
`endif
);

    localparam int CW = $clog2(N);

    state_t        state;
    logic [N:0]    a_reg;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  m_reg;
    logic [CW-1:0] cnt;
    logic [N:0]    a_next;
    logic [N-1:0]  q_next;

    divider_step #(.N(N)) u_step (
        .a      (a_reg),
        .q      (q_reg),
        .m      (m_reg),
        .a_next (a_next),
        .q_next (q_next)
    );

    // Control FSM, iteration registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        // NOTE: the whole datapath is only a handful of flops, so every register is reset;
        // sequential state uses non-blocking assignments throughout.
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            cnt       <= '0;
`ifdef DIVIDER_DBZ_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
`ifdef DIVIDER_DBZ_EN
                        if (divisor == '0) begin
                            // Zero divisor: skip the iterations and report immediately.
                            state       <= S_DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= S_RUN;
                            busy        <= 1'b1;
                            a_reg       <= '0;
                            q_reg       <= dividend;
                            m_reg       <= divisor;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                        end
`else
                        state <= S_RUN;
                        busy  <= 1'b1;
                        a_reg <= '0;
                        q_reg <= dividend;
                        m_reg <= divisor;
                        cnt   <= '0;
`endif
                    end
                end
                S_RUN: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= a_next[N-1:0];
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_restoring.sv
// Self-checking bench for divider_restoring (N=4): directed vector table,
// hand-written corner sequences and an exhaustive sweep, with results checked
// by a scoreboard queue that is popped on every done pulse.
module tb_divider_restoring;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] dd;
        logic [N-1:0] dv;
        logic [N-1:0] q;
        logic [N-1:0] r;
    } vec_t;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
`ifdef DIVIDER_DBZ_EN
    logic         div_by_zero;
`endif

    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];
    exp_t sb_e;

    divider_restoring #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIVIDER_DBZ_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(sb_e.q));
                check("remainder", 32'(remainder), 32'(sb_e.r));
            end
        end
    end

    // Start one division, scramble the operand inputs after acceptance, then
    // wait (bounded) for done and check latency, busy length and hold behaviour.
    task automatic run_div(input logic [N-1:0] dd, input logic [N-1:0] dv,
                           input logic [N-1:0] eq, input logic [N-1:0] er,
                           input int exp_lat, input bit exp_dbz);
        int lat;
        int busy_cnt;
        bit seen;
        exp_t e;
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        e.q = eq;
        e.r = er;
        sb.push_back(e);
        @(posedge clk);
        lat = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            if (lat == 0) begin
                start    = 1'b0;
                dividend = N'($urandom);
                divisor  = N'($urandom);
            end
            lat++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) seen = 1'b1;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(busy_cnt), exp_dbz ? 32'd0 : 32'(N));
`ifdef DIVIDER_DBZ_EN
        check("div_by_zero", 32'(div_by_zero), 32'(exp_dbz));
`endif
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
        check("quotient_hold", 32'(quotient), 32'(eq));
        check("remainder_hold", 32'(remainder), 32'(er));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   done_cnt;
        int   zlat;
        bit   zdbz;

`ifdef DIVIDER_DBZ_EN
        zlat = 1;
        zdbz = 1'b1;
`else
        zlat = N + 1;
        zdbz = 1'b0;
`endif

        vecs[0] = '{dd: 4'd13, dv: 4'd3,  q: 4'd4,  r: 4'd1};
        vecs[1] = '{dd: 4'd15, dv: 4'd1,  q: 4'd15, r: 4'd0};
        vecs[2] = '{dd: 4'd7,  dv: 4'd9,  q: 4'd0,  r: 4'd7};
        vecs[3] = '{dd: 4'd9,  dv: 4'd0,  q: 4'd15, r: 4'd9};
        vecs[4] = '{dd: 4'd0,  dv: 4'd5,  q: 4'd0,  r: 4'd0};
        vecs[5] = '{dd: 4'd15, dv: 4'd15, q: 4'd1,  r: 4'd0};
        vecs[6] = '{dd: 4'd8,  dv: 4'd2,  q: 4'd4,  r: 4'd0};

        // Reset with start held high: nothing may leave IDLE.
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 32'(busy), 32'd0);

        // Directed table, back to back (each restart lands in the cycle after done).
        for (int i = 0; i < 7; i++) begin
            run_div(vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r,
                    (vecs[i].dv == '0) ? zlat : N + 1,
                    (vecs[i].dv == '0) ? zdbz : 1'b0);
        end

        // Second start mid-RUN with new operands must be ignored.
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        sb.push_back('{q: 4'd4, r: 4'd1});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 4'd15;
        divisor  = 4'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        repeat (N + 6) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("repulse_single_done", 32'(done_cnt), 32'd1);
        check("repulse_quotient", 32'(quotient), 32'd4);

        // Reset in the middle of a division: outputs cleared, no done pulse.
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        rst = 1'b0;
        done_cnt = 0;
        repeat (N + 4) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        check("midrst_no_activity", 32'(done_cnt), 32'd0);

        // Exhaustive sweep of all non-zero divisors against / and %.
        for (int dd = 0; dd < 16; dd++) begin
            for (int dv = 1; dv < 16; dv++) begin
                run_div(N'(dd), N'(dv), N'(dd / dv), N'(dd % dv), N + 1, 1'b0);
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
